pipeline_ctrl: RTL

Central hazard and stall controller for the 5-stage rv32i pipeline. Generates load/flush for the PC and the four stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) from three sources: memory-wait stalls, EX-stage branch redirects and load-use hazards. It tracks split I/D memory responses across multi-cycle stalls. Outputs are combinational from inputs plus internal state; the state is two completion flags and the optional counters.

---
 rtl/rv32i_types.sv | 27 ++
 rtl/pipe_perf_counter.sv | 33 +++
 rtl/pipeline_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: the per-stage load/flush control bundle used by the hazard controller.
package rv32i_types;

    localparam int REG_ADDR_W = 5;
    localparam int PERF_W     = 32;

    typedef struct packed {
        logic pc_load;
        logic pc_sel;
        logic ifid_load;
        logic ifid_flush;
        logic idex_load;
        logic idex_flush;
        logic exmem_load;
        logic exmem_flush;
        logic memwb_load;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Source operand collides with a non-x0 destination.
    function automatic logic reg_conflict(input logic [REG_ADDR_W-1:0] rd,
                                          input logic [REG_ADDR_W-1:0] rs,
                                          input logic                  use_rs);
        return use_rs && (rd != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating 32-bit event counter with enable; only built when PIPE_CTRL_PERF_EN is defined.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_counter
    import rv32i_types::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [PERF_W-1:0] cnt_o
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage rv32i pipeline (memory stalls, branch redirects, load-use).
// Optional performance counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  imem_req_i,
    input  logic                  imem_resp_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_resp_i,
    input  logic                  br_taken_i,
    input  logic                  idex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_addr_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] ifid_rs2_addr_i,
    input  logic                  ifid_use_rs1_i,
    input  logic                  ifid_use_rs2_i,
    output logic                  pc_load_o,
    output logic                  pc_sel_o,
    output logic                  ifid_load_o,
    output logic                  ifid_flush_o,
    output logic                  idex_load_o,
    output logic                  idex_flush_o,
    output logic                  exmem_load_o,
    output logic                  exmem_flush_o,
    output logic                  memwb_load_o,
    output logic                  memwb_flush_o,
    output logic                  imem_latch_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_mem_stall_o,
    output logic [PERF_W-1:0]     perf_lu_bubble_o,
    output logic [PERF_W-1:0]     perf_br_flush_o
`endif
);

    logic       imem_done_q, imem_done_d;
    logic       dmem_done_q, dmem_done_d;
    logic       i_ok, d_ok, mem_stall, lu;
    logic       win_stall, win_br, win_lu;
    pipe_ctrl_t ctrl;

    assign i_ok      = ~imem_req_i | imem_resp_i | imem_done_q;
    assign d_ok      = ~dmem_req_i | dmem_resp_i | dmem_done_q;
    assign mem_stall = ~(i_ok & d_ok);

    assign lu = idex_mem_read_i &
                (reg_conflict(idex_rd_addr_i, ifid_rs1_addr_i, ifid_use_rs1_i) |
                 reg_conflict(idex_rd_addr_i, ifid_rs2_addr_i, ifid_use_rs2_i));

    assign win_stall = mem_stall;
    assign win_br    = ~mem_stall & br_taken_i;
    assign win_lu    = ~mem_stall & ~br_taken_i & lu;

    always_comb begin
        ctrl             = '0;
        ctrl.pc_load     = 1'b1;
        ctrl.ifid_load   = 1'b1;
        ctrl.idex_load   = 1'b1;
        ctrl.exmem_load  = 1'b1;
        ctrl.memwb_load  = 1'b1;
        if (win_stall) begin
            // Freeze everything; the WB bubble keeps a held MEM/WB entry from retiring twice.
            ctrl             = '0;
            ctrl.memwb_flush = 1'b1;
        end else if (win_br) begin
            ctrl.pc_sel      = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
        end else if (win_lu) begin
            ctrl.pc_load     = 1'b0;
            ctrl.ifid_load   = 1'b0;
            ctrl.idex_flush  = 1'b1;
        end
    end

    // Completion flags only accumulate while stalled; any advancing cycle drops them.
    always_comb begin
        imem_done_d = 1'b0;
        dmem_done_d = 1'b0;
        if (mem_stall) begin
            imem_done_d = imem_done_q | imem_resp_i;
            dmem_done_d = dmem_done_q | dmem_resp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
        end else begin
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
        end
    end

    assign pc_load_o     = rst_ni & ctrl.pc_load;
    assign pc_sel_o      = rst_ni & ctrl.pc_sel;
    assign ifid_load_o   = rst_ni & ctrl.ifid_load;
    assign ifid_flush_o  = rst_ni & ctrl.ifid_flush;
    assign idex_load_o   = rst_ni & ctrl.idex_load;
    assign idex_flush_o  = rst_ni & ctrl.idex_flush;
    assign exmem_load_o  = rst_ni & ctrl.exmem_load;
    assign exmem_flush_o = rst_ni & ctrl.exmem_flush;
    assign memwb_load_o  = rst_ni & ctrl.memwb_load;
    assign memwb_flush_o = rst_ni & ctrl.memwb_flush;
    assign imem_latch_o  = rst_ni & mem_stall & imem_resp_i;

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_counter u_perf_mem_stall (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (win_stall),
        .cnt_o  (perf_mem_stall_o)
    );

    pipe_perf_counter u_perf_lu_bubble (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (win_lu),
        .cnt_o  (perf_lu_bubble_o)
    );

    pipe_perf_counter u_perf_br_flush (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (win_br),
        .cnt_o  (perf_br_flush_o)
    );
`endif

endmodule
